pulse_scheduler: RTL and testbench



---
 rtl/pulse_scheduler_if.sv | 35 +++
 rtl/pulse_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_pulse_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pulse_scheduler_if.sv
// Requester/generator-side signal bundle for pulse_scheduler.
// The scheduler uses the slave modport; whoever drives requests and the generator pulse uses master.
interface pulse_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               err;
  logic               busy;
  logic [GW-1:0]      grant_id;
  logic               gen_start;
  logic               gen_pulse;

  modport master (
    output req,
    output gen_pulse,
    input  ack,
    input  err,
    input  busy,
    input  grant_id,
    input  gen_start
  );

  modport slave (
    input  req,
    input  gen_pulse,
    output ack,
    output err,
    output busy,
    output grant_id,
    output gen_start
  );
endinterface

// File: rtl/pulse_scheduler.sv
// Round-robin arbiter sharing one pulse generator among NUM_REQ requesters;
// it checks the returned pulse width and timeout, then acks the served requester.
module pulse_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int PULSE_WIDTH = 3,
  parameter int GAP_CYCLES  = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pulse_scheduler_if.slave      bus
);
  localparam int GW      = $clog2(NUM_REQ);
  localparam int WW      = $clog2(TIMEOUT + 1);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int TW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_HIGH = 3'd2,
    WAIT_LOW  = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [WW-1:0]      width_q, width_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               gen_start_q, gen_start_d;

  logic               found_s;
  logic               hi_found_s;
  logic [GW-1:0]      hi_idx_s;
  logic               lo_found_s;
  logic [GW-1:0]      lo_idx_s;
  logic [GW-1:0]      winner_s;
  logic               done_s;
  logic               bad_s;

  // First set request strictly above the pointer wins; otherwise wrap to the lowest set request.
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (bus.req[GW'(j)]) begin
        if (!hi_found_s && (GW'(j) > rr_q)) begin
          hi_found_s = 1'b1;
          hi_idx_s   = GW'(j);
        end else begin
          hi_found_s = hi_found_s;
        end
        if (!lo_found_s) begin
          lo_found_s = 1'b1;
          lo_idx_s   = GW'(j);
        end else begin
          lo_found_s = lo_found_s;
        end
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    found_s  = |bus.req;
    winner_s = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Next-state and next-output computation for the service FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    width_d     = width_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    err_d       = 1'b0;
    gen_start_d = 1'b0;
    done_s      = 1'b0;
    bad_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_s) begin
          grant_d     = winner_s;
          rr_d        = winner_s;
          gen_start_d = 1'b1;
          state_d     = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // gen_pulse is deliberately not sampled here.
        timer_d = '0;
        width_d = '0;
        state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.gen_pulse) begin
          timer_d = '0;
          width_d = WW'(1);
          state_d = WAIT_LOW;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          done_s = 1'b1;
          bad_s  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_LOW: begin
        if (!bus.gen_pulse) begin
          done_s = 1'b1;
          bad_s  = (width_q != WW'(PULSE_WIDTH));
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          done_s = 1'b1;
          bad_s  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
          width_d = (width_q == WW'(TIMEOUT)) ? width_q : (width_q + WW'(1));
        end
      end
      GAP: begin
        if (timer_q >= TW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done_s) begin
      ack_d   = NUM_REQ'(1) << grant_q;
      err_d   = bad_s;
      timer_d = '0;
      state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
    end else begin
      err_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset restarts priority at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      width_q     <= '0;
      rr_q        <= GW'(NUM_REQ - 1);
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      gen_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      width_q     <= width_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      gen_start_q <= gen_start_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.gen_start = gen_start_q;
endmodule

// File: tb/tb_pulse_scheduler.sv
// Table-driven bench for pulse_scheduler with a behavioural pulse generator
// that rises one cycle after gen_start and stays high for model_w cycles.
module tb_pulse_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   model_w   = 3;
  int   pulse_cnt = 0;

  pulse_scheduler_if #(.NUM_REQ(4)) bus ();

  pulse_scheduler #(
    .NUM_REQ(4), .PULSE_WIDTH(3), .GAP_CYCLES(1), .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // model_w == 0 models a generator that never answers.
  always @(posedge clk) begin
    if (bus.gen_start && model_w != 0) pulse_cnt <= model_w;
    else if (pulse_cnt != 0)           pulse_cnt <= pulse_cnt - 1;
  end
  assign bus.gen_pulse = (pulse_cnt != 0);

  typedef struct {
    logic [3:0] req;
    bit         hold;   // keep req asserted after the ack
    bit         drop;   // release req right after gen_start
    int         width;  // generator pulse width, 0 = never
    logic [3:0] ack;
    bit         err;
    int         grant;
    int         lat;    // cycles from gen_start to ack
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int         start_idx  = -1;
    int         start_cnt  = 0;
    int         ack_idx    = -1;
    logic [3:0] ack_v      = 4'd0;
    logic       err_v      = 1'b0;
    int         gid        = 0;
    logic       busy_ack   = 1'b0;
    logic       busy_after = 1'b1;
    logic [3:0] ack_after  = 4'd0;
    model_w = v.width;
    bus.req = v.req;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.gen_start) begin
        start_cnt++;
        if (start_idx < 0) start_idx = i;
        if (v.drop) bus.req = 4'd0;
      end
      if (ack_idx >= 0) begin
        ack_after  = bus.ack;
        busy_after = bus.busy;
        break;
      end
      if (bus.ack != 4'd0) begin
        ack_idx  = i;
        ack_v    = bus.ack;
        err_v    = bus.err;
        gid      = int'(bus.grant_id);
        busy_ack = bus.busy;
      end
    end
    if (!v.hold) bus.req = 4'd0;
    check({tag, "_ack_seen"}, int'(ack_idx >= 0), 1);
    if (ack_idx >= 0) begin
      check({tag, "_start_lat"},   start_idx, 1);
      check({tag, "_start_cnt"},   start_cnt, 1);
      check({tag, "_ack"},         int'(ack_v), int'(v.ack));
      check({tag, "_err"},         int'(err_v), int'(v.err));
      check({tag, "_grant"},       gid, v.grant);
      check({tag, "_lat"},         ack_idx - start_idx, v.lat);
      check({tag, "_busy_at_ack"}, int'(busy_ack), 1);
      check({tag, "_busy_after"},  int'(busy_after), 0);
      check({tag, "_ack_once"},    int'(ack_after), 0);
    end
  endtask

  initial begin
    vec_t v_rst;
    vec_t v_drop;
    int   k;
    int   cnt;

    vecs[0]  = '{4'b1111, 1'b1, 1'b0, 3,  4'b0001, 1'b0, 0, 5};
    vecs[1]  = '{4'b1111, 1'b1, 1'b0, 3,  4'b0010, 1'b0, 1, 5};
    vecs[2]  = '{4'b1111, 1'b1, 1'b0, 3,  4'b0100, 1'b0, 2, 5};
    vecs[3]  = '{4'b1111, 1'b1, 1'b0, 3,  4'b1000, 1'b0, 3, 5};
    vecs[4]  = '{4'b1111, 1'b0, 1'b0, 3,  4'b0001, 1'b0, 0, 5};
    vecs[5]  = '{4'b0100, 1'b0, 1'b0, 3,  4'b0100, 1'b0, 2, 5};
    vecs[6]  = '{4'b0001, 1'b0, 1'b0, 0,  4'b0001, 1'b1, 0, 17};
    vecs[7]  = '{4'b0001, 1'b0, 1'b0, 5,  4'b0001, 1'b1, 0, 7};
    vecs[8]  = '{4'b0001, 1'b0, 1'b0, 3,  4'b0001, 1'b0, 0, 5};
    vecs[9]  = '{4'b0010, 1'b0, 1'b0, 1,  4'b0010, 1'b1, 1, 3};
    vecs[10] = '{4'b1000, 1'b0, 1'b0, 16, 4'b1000, 1'b1, 3, 18};
    vecs[11] = '{4'b0100, 1'b0, 1'b0, 20, 4'b0100, 1'b1, 2, 18};
    vecs[12] = '{4'b0011, 1'b0, 1'b0, 3,  4'b0001, 1'b0, 0, 5};
    vecs[13] = '{4'b1010, 1'b0, 1'b0, 3,  4'b0010, 1'b0, 1, 5};
    v_rst    = '{4'b1001, 1'b0, 1'b0, 3,  4'b0001, 1'b0, 0, 5};
    v_drop   = '{4'b0010, 1'b0, 1'b1, 3,  4'b0010, 1'b0, 1, 5};

    reset   = 1'b1;
    bus.req = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_ack",       int'(bus.ack), 0);
    check("rst_err",       int'(bus.err), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_grant",     int'(bus.grant_id), 0);
    check("rst_gen_start", int'(bus.gen_start), 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while the served pulse is in WAIT_LOW.
    model_w = 3;
    bus.req = 4'b0100;
    k = 0;
    while (!bus.gen_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("mid_start_seen", int'(bus.gen_start), 1);
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    bus.req = 4'd0;
    @(negedge clk);
    check("mid_busy",      int'(bus.busy), 0);
    check("mid_gen_start", int'(bus.gen_start), 0);
    check("mid_ack",       int'(bus.ack), 0);
    check("mid_err",       int'(bus.err), 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack != 4'd0 || bus.err || bus.busy) cnt++;
    end
    check("mid_quiet", cnt, 0);
    run_vec(v_rst, "post_rst");

    // Requester 1 drops its request right after gen_start.
    run_vec(v_drop, "drop");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.gen_start) cnt++;
    end
    check("drop_no_restart", cnt, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
